// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 execute-side sequencer:
// FSM state encodings and the one-hot IDU instruction-type codes.
package ysyx_25020047_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_WAIT   = 3'd2;
    localparam state_t S_DECODE = 3'd3;
    localparam state_t S_EXEC   = 3'd4;
    localparam state_t S_WB     = 3'd5;
    localparam state_t S_HALT   = 3'd6;
    localparam state_t S_TRAP   = 3'd7;

    localparam logic [7:0] INST_ADDI   = 8'h01;
    localparam logic [7:0] INST_JALR   = 8'h02;
    localparam logic [7:0] INST_EBREAK = 8'h04;

endpackage

// File: rtl/ysyx_25020047_ctrl_wdt.sv
// IMEM response watchdog: 8-bit counter cleared on entry to WAIT,
// advanced each WAIT cycle; expired_o marks the last allowed cycle.
// Ports: clk, rst_n, clr_i (entering WAIT), inc_i (in WAIT), expired_o.
module ysyx_25020047_ctrl_wdt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    // expired_o is raised during the WAIT cycle that brings the
    // count up to TIMEOUT_CYCLES, so the FSM can leave on that edge.
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_25020047_exu_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with commit
// strobes, sticky halt/trap and a retired-instruction counter.
// Ports: clk, rst_n, start; IMEM req/gnt/rvalid/rdata; inst_q to IDU;
// inst_type, exu_reg_wen, exu_pc_wen in; rf_wen, pc_upd, pc_sel,
// halt, trap, retired out.
// Optional: YSYX_25020047_CTRL_TIMEOUT_EN adds an IMEM WAIT timeout.
module ysyx_25020047_exu_ctrl
    import ysyx_25020047_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst_q,
    input  logic [7:0]       inst_type,
    input  logic             exu_reg_wen,
    input  logic             exu_pc_wen,
    output logic             rf_wen,
    output logic             pc_upd,
    output logic             pc_sel,
    output logic             halt,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        inst_d;
    logic [CNT_W-1:0]   retired_q;
    logic [CNT_W-1:0]   retired_d;
    logic               tmo;

`ifdef YSYX_25020047_CTRL_TIMEOUT_EN
    ysyx_25020047_ctrl_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    ((state_q == S_FETCH) && imem_gnt && !imem_rvalid),
        .inc_i    (state_q == S_WAIT),
        .expired_o(tmo)
    );
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        inst_d  = imem_rdata;
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response on the limit cycle still wins.
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_DECODE;
                end else if (tmo) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                case (inst_type)
                    INST_ADDI,
                    INST_JALR: begin
                        state_d = S_EXEC;
                    end
                    INST_EBREAK: begin
                        // ebreak retires without any commit strobe.
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_HALT;
                    end
                    default: begin
                        state_d = S_TRAP;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            inst_q    <= 32'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req = (state_q == S_FETCH);
    assign rf_wen   = (state_q == S_WB) && exu_reg_wen;
    assign pc_upd   = (state_q == S_WB);
    assign pc_sel   = (state_q == S_WB) && exu_pc_wen;
    assign halt     = (state_q == S_HALT);
    assign trap     = (state_q == S_TRAP);
    assign retired  = retired_q;

endmodule

// File: tb/tb_ysyx_25020047_exu_ctrl.sv
// Directed bench for ysyx_25020047_exu_ctrl: fetch paths, commit
// strobes, halt/trap, async reset and the optional WAIT timeout.
module tb_ysyx_25020047_exu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_q;
    logic [7:0]  inst_type;
    logic        exu_reg_wen;
    logic        exu_pc_wen;
    logic        rf_wen;
    logic        pc_upd;
    logic        pc_sel;
    logic        halt;
    logic        trap;
    logic [31:0] retired;

    int total;
    int bad;

    ysyx_25020047_exu_ctrl #(
        .CNT_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_q     (inst_q),
        .inst_type  (inst_type),
        .exu_reg_wen(exu_reg_wen),
        .exu_pc_wen (exu_pc_wen),
        .rf_wen     (rf_wen),
        .pc_upd     (pc_upd),
        .pc_sel     (pc_sel),
        .halt       (halt),
        .trap       (trap),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    // Leave IDLE: after return the DUT is in FETCH.
    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;
        inst_type = 8'h00;
        exu_reg_wen = 1'b0;
        exu_pc_wen = 1'b0;
        #3;
        chk("rst_req", imem_req, 0);
        chk("rst_inst", inst_q, 0);
        chk("rst_ret", retired, 0);
        chk("rst_flags", {rf_wen, pc_upd, pc_sel, halt, trap}, 0);
        #9;
        rst_n = 1'b1;
        step();
        chk("idle_req", imem_req, 0);

        // addi, gnt and rvalid together
        go();
        chk("addi_req", imem_req, 1);
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0010_0093;
        inst_type = 8'h01;
        exu_reg_wen = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        chk("addi_inst", inst_q, 32'h0010_0093);
        chk("addi_dec_req", imem_req, 0);
        chk("addi_dec_wen", rf_wen, 0);
        step();
        chk("addi_ex_wen", {rf_wen, pc_upd}, 0);
        step();
        chk("addi_wb", {rf_wen, pc_upd, pc_sel}, 3'b110);
        chk("addi_wb_ret", retired, 0);
        step();
        chk("addi_post_wen", rf_wen, 0);
        chk("addi_ret", retired, 1);
        chk("addi_refetch", imem_req, 1);

        // jalr, response three cycles after grant
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("jalr_wait_req", imem_req, 0);
        step();
        step();
        chk("jalr_wait_hold", {imem_req, pc_upd}, 0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_8067;
        inst_type = 8'h02;
        exu_pc_wen = 1'b1;
        step();
        chk("jalr_inst", inst_q, 32'h0000_8067);
        imem_rdata = 32'hdead_beef;
        step();
        imem_rvalid = 1'b0;
        chk("jalr_ignore_rv", inst_q, 32'h0000_8067);
        step();
        chk("jalr_wb", {rf_wen, pc_upd, pc_sel}, 3'b111);
        step();
        chk("jalr_ret", retired, 2);

        // ebreak
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0010_0073;
        inst_type = 8'h04;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        chk("ebr_dec_halt", halt, 0);
        step();
        chk("ebr_halt", halt, 1);
        chk("ebr_strobes", {rf_wen, pc_upd}, 0);
        chk("ebr_ret", retired, 3);
        start = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        step();
        step();
        start = 1'b0;
        imem_rvalid = 1'b0;
        chk("ebr_sticky", {halt, imem_req}, 2'b10);
        chk("ebr_inst_keep", inst_q, 32'h0010_0073);
        chk("ebr_ret_keep", retired, 3);
        rst_n = 1'b0;
        #1;
        chk("ebr_async_rst", {halt, retired}, 0);
        rst_n = 1'b1;
        step();

        // illegal: zero type
        go();
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        inst_type = 8'h00;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        step();
        chk("ill0_trap", {trap, halt}, 2'b10);
        chk("ill0_ret", retired, 0);
        step();
        chk("ill0_sticky", {trap, pc_upd}, 2'b10);
        do_reset();

        // illegal: multi-hot type
        go();
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        inst_type = 8'h03;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        step();
        chk("ill3_trap", trap, 1);
        chk("ill3_ret", retired, 0);
        do_reset();

        // reset asserted during WAIT
        go();
        imem_rdata = 32'h0000_0013;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        inst_type = 8'h01;
        step();
        imem_rvalid = 1'b0;
        step();
        step();
        step();
        step();
        imem_gnt = 1'b0;
        step();
        chk("wr_ret_pre", retired, 1);
        chk("wr_in_wait", imem_req, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wr_async", {imem_req, rf_wen, pc_upd, pc_sel, halt, trap}, 0);
        chk("wr_async_cnt", {inst_q, retired}, 0);
        #3;
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("wr_idle", imem_req, 0);
        go();
        chk("wr_restart", imem_req, 1);

`ifdef YSYX_25020047_CTRL_TIMEOUT_EN
        // timeout expires with no response
        do_reset();
        go();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        step();
        step();
        chk("to_w4_trap", trap, 0);
        step();
        chk("to_trap", trap, 1);
        do_reset();

        // response on the limit cycle wins
        go();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        step();
        step();
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0020_0113;
        inst_type = 8'h01;
        step();
        imem_rvalid = 1'b0;
        chk("to_win_trap", trap, 0);
        chk("to_win_inst", inst_q, 32'h0020_0113);
        step();
        step();
        chk("to_win_wb", pc_upd, 1);
`else
        // no timeout: WAIT holds well past four cycles
        do_reset();
        go();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        chk("nto_hold", {trap, imem_req}, 0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0030_0193;
        inst_type = 8'h01;
        step();
        imem_rvalid = 1'b0;
        chk("nto_inst", inst_q, 32'h0030_0193);
        step();
        step();
        chk("nto_wb", pc_upd, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
